// File: rtl/demux_1a2_stream.sv
// 1-to-2 stream demux with a 2-entry buffer per output; 1-cycle latency, In_Ready depends only on Selector and buffer state.
// DEMUX_COUNT_EN adds Count0/Count1, wrapping counters of words delivered on each output.
module demux_1a2_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Selector,
    input  logic [WIDTH-1:0] Input,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Output0,
    output logic             Out0_Valid,
    input  logic             Out0_Ready,
    output logic [WIDTH-1:0] Output1,
    output logic             Out1_Valid,
    input  logic             Out1_Ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] Count0,
    output logic [CNT_WIDTH-1:0] Count1
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0][1:0]       r_state;
    logic [1:0][WIDTH-1:0] r_head;
    logic [1:0][WIDTH-1:0] r_tail;

    logic [1:0] w_sel;
    logic [1:0] w_valid;
    logic [1:0] w_rdy;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    // Ready ignores the consumers on purpose: no combinational path from Outk_Ready to In_Ready.
    assign In_Ready = Selector ? (r_state[1] != FULL) : (r_state[0] != FULL);

    assign w_sel   = {Selector, ~Selector};
    assign w_valid = {r_state[1] != EMPTY, r_state[0] != EMPTY};
    assign w_rdy   = {Out1_Ready, Out0_Ready};
    assign w_push  = {2{In_Valid & In_Ready}} & w_sel;
    assign w_pop   = w_valid & w_rdy;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (r_state[k])
                    EMPTY: begin
                        if (w_push[k]) begin
                            r_head[k]  <= Input;
                            r_state[k] <= ONE;
                        end
                    end
                    ONE: begin
                        if (w_push[k] && w_pop[k]) begin
                            r_head[k] <= Input;
                        end else if (w_push[k]) begin
                            r_tail[k]  <= Input;
                            r_state[k] <= FULL;
                        end else if (w_pop[k]) begin
                            r_state[k] <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_pop[k]) begin
                            r_head[k]  <= r_tail[k];
                            r_state[k] <= ONE;
                        end
                    end
                    default: r_state[k] <= EMPTY;
                endcase
            end
        end
    end

    assign Output0    = r_head[0];
    assign Output1    = r_head[1];
    assign Out0_Valid = w_valid[0];
    assign Out1_Valid = w_valid[1];

`ifdef DEMUX_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop[0]) r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            if (w_pop[1]) r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
        end
    end

    assign Count0 = r_cnt0;
    assign Count1 = r_cnt1;
`else
    // CNT_WIDTH only sizes the counters; this empty block keeps it referenced in the counter-less build.
    if (CNT_WIDTH > 0) begin : g_no_count
    end
`endif

endmodule

// File: tb/tb_demux_1a2_stream.sv
// Directed bench for demux_1a2_stream; a per-output queue model predicts valid, ready and head data every cycle.
module tb_demux_1a2_stream;

`ifdef DEMUX_COUNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Selector = 1'b0;
    logic [7:0] Input = '0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Output0;
    logic       Out0_Valid;
    logic       Out0_Ready = 1'b0;
    logic [7:0] Output1;
    logic       Out1_Valid;
    logic       Out1_Ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] Count0;
    logic [CW-1:0] Count1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    demux_1a2_stream #(.WIDTH(8), .CNT_WIDTH(CW)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Selector   (Selector),
        .Input      (Input),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Output0    (Output0),
        .Out0_Valid (Out0_Valid),
        .Out0_Ready (Out0_Ready),
        .Output1    (Output1),
        .Out1_Valid (Out1_Valid),
        .Out1_Ready (Out1_Ready)
`ifdef DEMUX_COUNT_EN
        ,
        .Count0     (Count0),
        .Count1     (Count1)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive after the falling edge, check against the model, then update the model.
    task automatic step(input logic sel, input logic vld, input logic [7:0] d,
                        input logic r0, input logic r1);
        logic acc;
        @(negedge Clk);
        Selector   = sel;
        In_Valid   = vld;
        Input      = d;
        Out0_Ready = r0;
        Out1_Ready = r1;
        #1;
        chk("out0_valid", {31'd0, Out0_Valid}, {31'd0, q0.size() != 0});
        chk("out1_valid", {31'd0, Out1_Valid}, {31'd0, q1.size() != 0});
        chk("in_ready", {31'd0, In_Ready},
            {31'd0, sel ? (q1.size() < 2) : (q0.size() < 2)});
        acc = vld && In_Ready;
        if (q0.size() > 0) begin
            chk("out0_head", {24'd0, Output0}, {24'd0, q0[0]});
            if (r0) void'(q0.pop_front());
        end
        if (q1.size() > 0) begin
            chk("out1_head", {24'd0, Output1}, {24'd0, q1[0]});
            if (r1) void'(q1.pop_front());
        end
        if (acc) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
    endtask

    initial begin
        #1;
        chk("rst_out0_valid", {31'd0, Out0_Valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, Out1_Valid}, 32'd0);
        chk("rst_output0", {24'd0, Output0}, 32'd0);
        chk("rst_output1", {24'd0, Output1}, 32'd0);
        #21 Rst_n = 1'b1;

        // Alternating routing with both consumers ready.
        for (int j = 0; j < 32; j++) begin
            step((j % 2) == 0, 1'b1, 8'(j), 1'b1, 1'b1);
        end
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Fill buffer 0, third push refused, other output still flows.
        step(0, 1, 8'hA1, 0, 1);
        step(0, 1, 8'hA2, 0, 1);
        step(0, 1, 8'hA3, 0, 1);
        chk("full_in_ready", {31'd0, In_Ready}, 32'd0);
        step(1, 1, 8'h55, 0, 1);
        step(0, 1, 8'hA3, 1, 1);
        chk("full_pop_no_push", {31'd0, In_Ready}, 32'd0);
        step(0, 1, 8'hA3, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Simultaneous push and pop in ONE.
        step(0, 1, 8'h10, 0, 1);
        step(0, 1, 8'h20, 1, 1);
        step(0, 0, 8'h00, 0, 1);
        chk("pushpop_head", {24'd0, Output0}, 32'h20);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Fill both buffers, then asynchronous reset mid-cycle.
        step(0, 1, 8'hB0, 0, 0);
        step(0, 1, 8'hB1, 0, 0);
        step(1, 1, 8'hC0, 0, 0);
        step(1, 1, 8'hC1, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        In_Valid = 1'b0;
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", {31'd0, Out0_Valid}, 32'd0);
        chk("arst_out1_valid", {31'd0, Out1_Valid}, 32'd0);
        chk("arst_output0", {24'd0, Output0}, 32'd0);
        chk("arst_output1", {24'd0, Output1}, 32'd0);
        q0.delete();
        q1.delete();
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, In_Ready}, 32'd1);
        step(1, 1, 8'h77, 1, 1);
        step(0, 1, 8'h88, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

`ifdef DEMUX_COUNT_EN
        Rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #3 Rst_n = 1'b1;
        for (int j = 0; j < 17; j++) begin
            step(1, 1, 8'(j + 8'h40), 1, 1);
        end
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        chk("count1_wrap", {28'd0, Count1}, 32'd1);
        chk("count0_zero", {28'd0, Count0}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
